// File: rtl/cpu_bus_sequencer_pkg.sv
// Shared constants for the CPU bus sequencer: decoded target types, AXI response codes and
// FSM state encodings.
package cpu_bus_sequencer_pkg;

  localparam logic [2:0] ADDR_TYPE_NOT_OP  = 3'd0;
  localparam logic [2:0] ADDR_TYPE_ROM     = 3'd1;
  localparam logic [2:0] ADDR_TYPE_RAM     = 3'd2;
  localparam logic [2:0] ADDR_TYPE_BUTTON  = 3'd3;
  localparam logic [2:0] ADDR_TYPE_LED     = 3'd4;
  localparam logic [2:0] ADDR_TYPE_GPIO    = 3'd5;
  localparam logic [2:0] ADDR_TYPE_AXI     = 3'd6;
  localparam logic [2:0] ADDR_TYPE_UNKNOWN = 3'd7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [2:0] bus_state_t;

  localparam bus_state_t StIdle   = 3'd0;
  localparam bus_state_t StAxiAwW = 3'd1;
  localparam bus_state_t StAxiB   = 3'd2;
  localparam bus_state_t StAxiAr  = 3'd3;
  localparam bus_state_t StAxiR   = 3'd4;
  localparam bus_state_t StInt    = 3'd5;
  localparam bus_state_t StDone   = 3'd6;

  function automatic logic is_axi_type(input logic [2:0] t);
    return t == ADDR_TYPE_AXI;
  endfunction

  function automatic logic is_int_type(input logic [2:0] t);
    return (t >= ADDR_TYPE_ROM) && (t <= ADDR_TYPE_GPIO);
  endfunction

endpackage

// File: rtl/cpu_bus_sequencer_if.sv
// AXI4-Lite link between the CPU bus sequencer (master) and the interconnect (slave).
interface cpu_bus_sequencer_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/cpu_bus_sequencer_byte_lane_sel.sv
// Selects one byte lane of a 32-bit word by the low address bits.
module byte_lane_sel (
  input  logic [31:0] word_i,
  input  logic [1:0]  sel_i,
  output logic [7:0]  lane_o
);

  always_comb begin
    lane_o = word_i[7:0];
    unique case (sel_i)
      2'd0: lane_o = word_i[7:0];
      2'd1: lane_o = word_i[15:8];
      2'd2: lane_o = word_i[23:16];
      2'd3: lane_o = word_i[31:24];
      default: lane_o = word_i[7:0];
    endcase
  end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Runs one 8-bit CPU bus cycle against an AXI4-Lite target or the internal strobe port, holding
// the CPU in wait states until the target completes.
module cpu_bus_sequencer
  import cpu_bus_sequencer_pkg::*;
#(
  parameter int unsigned INT_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_valid,
  input  logic        is_read,
  input  logic [2:0]  addr_type,
  input  logic [31:0] a32,
  input  logic [31:0] d32,
  input  logic [3:0]  wstrb_in,
  output logic        cpu_wait,
  output logic [7:0]  cpu_rdata,
  output logic        err_sticky,
  output logic        int_en,
  output logic        int_we,
  output logic [2:0]  int_type,
  output logic [11:0] int_addr,
  output logic [7:0]  int_wdata,
  input  logic [7:0]  int_rdata,
  cpu_bus_sequencer_if.master m
);

  localparam logic [1:0] IntLast = 2'(INT_RD_LATENCY - 1);

  bus_state_t  state_q, state_d;
  logic        cyc_q;
  logic [31:0] addr_q, data_q;
  logic [3:0]  wstrb_q;
  logic        read_q;
  logic [2:0]  type_q;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0]  int_cnt_q, int_cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        idle, start;
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_wstrb;
  logic [2:0]  cur_type;
  logic        in_aw_w, in_ar;
  logic        awvalid, wvalid, arvalid;
  logic        aw_hs, w_hs, ar_hs, aw_fin, w_fin;
  logic [7:0]  rd_lane, wr_lane;

  // Targets see the live inputs in the start cycle so no cycle is lost to latching.
  assign idle      = (state_q == StIdle);
  assign start     = cyc_valid & ~cyc_q & idle & (addr_type != ADDR_TYPE_NOT_OP);
  assign cur_addr  = idle ? a32 : addr_q;
  assign cur_data  = idle ? d32 : data_q;
  assign cur_wstrb = idle ? wstrb_in : wstrb_q;
  assign cur_type  = idle ? addr_type : type_q;

  assign in_aw_w = (state_q == StAxiAwW) | (start & is_axi_type(addr_type) & ~is_read);
  assign in_ar   = (state_q == StAxiAr) | (start & is_axi_type(addr_type) & is_read);
  assign awvalid = in_aw_w & ~aw_done_q;
  assign wvalid  = in_aw_w & ~w_done_q;
  assign arvalid = in_ar;
  assign aw_hs   = awvalid & m.awready;
  assign w_hs    = wvalid & m.wready;
  assign ar_hs   = arvalid & m.arready;
  assign aw_fin  = aw_done_q | aw_hs;
  assign w_fin   = w_done_q | w_hs;

  assign m.awaddr  = cur_addr;
  assign m.awvalid = awvalid;
  assign m.wdata   = cur_data;
  assign m.wstrb   = cur_wstrb;
  assign m.wvalid  = wvalid;
  assign m.bready  = (state_q == StAxiB);
  assign m.araddr  = cur_addr;
  assign m.arvalid = arvalid;
  assign m.rready  = (state_q == StAxiR);

  assign int_en    = start & is_int_type(addr_type);
  assign int_we    = int_en & ~is_read;
  assign int_type  = cur_type;
  assign int_addr  = cur_addr[11:0];
  assign int_wdata = wr_lane;

  assign cpu_wait   = start | ~(idle | (state_q == StDone));
  assign cpu_rdata  = rdata_q;
  assign err_sticky = err_q;

  byte_lane_sel u_rd_lane (
    .word_i (m.rdata),
    .sel_i  (addr_q[1:0]),
    .lane_o (rd_lane)
  );

  byte_lane_sel u_wr_lane (
    .word_i (cur_data),
    .sel_i  (cur_addr[1:0]),
    .lane_o (wr_lane)
  );

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    int_cnt_d = int_cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          aw_done_d = aw_hs;
          w_done_d  = w_hs;
          int_cnt_d = '0;
          if (is_axi_type(addr_type)) begin
            if (is_read) state_d = ar_hs ? StAxiR : StAxiAr;
            else         state_d = (aw_fin && w_fin) ? StAxiB : StAxiAwW;
          end else if (is_int_type(addr_type)) begin
            state_d = StInt;
          end else begin
            state_d = StDone;
            rdata_d = 8'hFF;
          end
        end
      end
      StAxiAwW: begin
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) state_d = StAxiB;
      end
      StAxiB: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (m.bvalid) begin
          err_d   = err_q | (m.bresp != RESP_OKAY);
          state_d = StDone;
        end
      end
      StAxiAr: if (ar_hs) state_d = StAxiR;
      StAxiR: begin
        if (m.rvalid) begin
          rdata_d = (m.rresp != RESP_OKAY) ? 8'hFF : rd_lane;
          err_d   = err_q | (m.rresp != RESP_OKAY);
          state_d = StDone;
        end
      end
      StInt: begin
        if (!read_q) begin
          state_d = StDone;
        end else if (int_cnt_q == IntLast) begin
          rdata_d = int_rdata;
          state_d = StDone;
        end else begin
          int_cnt_d = int_cnt_q + 2'd1;
        end
      end
      StDone: if (!cyc_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // cyc_q resets high so a cycle already live when reset releases is never started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      int_cnt_q <= '0;
      rdata_q   <= 8'hFF;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_valid;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      int_cnt_q <= int_cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      wstrb_q <= '0;
      read_q  <= 1'b0;
      type_q  <= ADDR_TYPE_NOT_OP;
    end else if (start) begin
      addr_q  <= a32;
      data_q  <= d32;
      wstrb_q <= wstrb_in;
      read_q  <= is_read;
      type_q  <= addr_type;
    end
  end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Randomised bench for cpu_bus_sequencer: an AXI/internal responder with programmable delays and a
// transaction-level model of wait length, returned byte, error flag and target activity.
module tb_cpu_bus_sequencer;
  import cpu_bus_sequencer_pkg::*;

  localparam int INT_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_valid, is_read;
  logic [2:0]  addr_type;
  logic [31:0] a32, d32;
  logic [3:0]  wstrb_in;
  logic        cpu_wait, err_sticky, int_en, int_we;
  logic [7:0]  cpu_rdata, int_wdata, int_rdata;
  logic [2:0]  int_type;
  logic [11:0] int_addr;

  cpu_bus_sequencer_if bus ();

  cpu_bus_sequencer #(.INT_RD_LATENCY(INT_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cyc_valid  (cyc_valid),
    .is_read    (is_read),
    .addr_type  (addr_type),
    .a32        (a32),
    .d32        (d32),
    .wstrb_in   (wstrb_in),
    .cpu_wait   (cpu_wait),
    .cpu_rdata  (cpu_rdata),
    .err_sticky (err_sticky),
    .int_en     (int_en),
    .int_we     (int_we),
    .int_type   (int_type),
    .int_addr   (int_addr),
    .int_wdata  (int_wdata),
    .int_rdata  (int_rdata),
    .m          (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder configuration and observations.
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  b_resp_cfg, r_resp_cfg;
  logic [31:0] r_data_cfg;
  logic [7:0]  int_val;
  int          n_aw, n_w, n_ar, n_int, n_extra;
  logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
  logic [3:0]  seen_wstrb;
  logic [11:0] seen_int_addr;
  logic [2:0]  seen_int_type;
  logic        seen_int_we;
  logic [7:0]  seen_int_wdata;

  // Model state.
  logic [7:0]  exp_rdata;
  logic        err_model;

  initial begin : responder
    int  aw_wait, w_wait, b_wait, ar_wait, r_wait, int_pend;
    bit  aw_got, w_got, ar_got, b_taken, r_taken;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    int_rdata = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0; int_pend = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_taken = 0; r_taken = 0;
    n_aw = 0; n_w = 0; n_ar = 0; n_int = 0; n_extra = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0; int_pend = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_taken = 0; r_taken = 0;
        continue;
      end
      // Internal port: read data valid only INT_LAT cycles after the strobe.
      if (int_pend > 0) begin
        int_pend--;
        int_rdata = (int_pend == 0) ? int_val : ~int_val;
      end else begin
        int_rdata = ~int_val;
      end
      if (int_en) begin
        n_int++;
        seen_int_addr = int_addr; seen_int_type = int_type;
        seen_int_we = int_we; seen_int_wdata = int_wdata;
        int_pend = INT_LAT;
      end
      if ((bus.awvalid && aw_got) || (bus.wvalid && w_got) || (bus.arvalid && ar_got)) n_extra++;
      // Responses first so they never coincide with their own request handshake.
      if (b_taken) begin
        bus.bvalid = 0; b_taken = 0; aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      end else if (aw_got && w_got) begin
        if (b_wait >= b_dly) begin bus.bvalid = 1; bus.bresp = b_resp_cfg; end
        b_wait++;
        if (bus.bvalid && bus.bready) b_taken = 1;
      end
      if (r_taken) begin
        bus.rvalid = 0; r_taken = 0; ar_got = 0; ar_wait = 0; r_wait = 0;
      end else if (ar_got) begin
        if (r_wait >= r_dly) begin
          bus.rvalid = 1; bus.rdata = r_data_cfg; bus.rresp = r_resp_cfg;
        end
        r_wait++;
        if (bus.rvalid && bus.rready) r_taken = 1;
      end
      if (bus.awvalid && !aw_got) begin
        bus.awready = (aw_wait >= aw_dly); aw_wait++;
        if (bus.awready) begin aw_got = 1; n_aw++; seen_awaddr = bus.awaddr; end
      end else bus.awready = 0;
      if (bus.wvalid && !w_got) begin
        bus.wready = (w_wait >= w_dly); w_wait++;
        if (bus.wready) begin
          w_got = 1; n_w++; seen_wdata = bus.wdata; seen_wstrb = bus.wstrb;
        end
      end else bus.wready = 0;
      if (bus.arvalid && !ar_got) begin
        bus.arready = (ar_wait >= ar_dly); ar_wait++;
        if (bus.arready) begin ar_got = 1; n_ar++; seen_araddr = bus.araddr; end
      end else bus.arready = 0;
    end
  end

  task automatic scramble_inputs();
    is_read   = 1'($urandom);
    addr_type = 3'($urandom);
    a32       = $urandom;
    d32       = $urandom;
    wstrb_in  = 4'($urandom);
  endtask

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic run_cycle(input logic rd, input logic [2:0] typ, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] ws);
    int   exp_wait, wl, aw0, w0, ar0, i0, x0;
    logic is_axi, is_int;
    logic [7:0] lane;
    is_axi = (typ == ADDR_TYPE_AXI);
    is_int = (typ >= ADDR_TYPE_ROM) && (typ <= ADDR_TYPE_GPIO);
    lane   = 8'(d >> (8 * int'(a[1:0])));
    if (typ == ADDR_TYPE_NOT_OP) begin
      exp_wait = 0;
    end else if (typ == ADDR_TYPE_UNKNOWN) begin
      exp_wait = 1; exp_rdata = 8'hFF;
    end else if (is_int) begin
      exp_wait = rd ? 1 + INT_LAT : 2;
      if (rd) exp_rdata = int_val;
    end else if (rd) begin
      exp_wait = ar_dly + 2 + r_dly;
      exp_rdata = (r_resp_cfg != 2'b00) ? 8'hFF : 8'(r_data_cfg >> (8 * int'(a[1:0])));
      if (r_resp_cfg != 2'b00) err_model = 1'b1;
    end else begin
      exp_wait = ((aw_dly > w_dly) ? aw_dly : w_dly) + 2 + b_dly;
      if (b_resp_cfg != 2'b00) err_model = 1'b1;
    end
    aw0 = n_aw; w0 = n_w; ar0 = n_ar; i0 = n_int; x0 = n_extra;

    @(posedge clk); #1;
    cyc_valid = 1'b1; is_read = rd; addr_type = typ; a32 = a; d32 = d; wstrb_in = ws;
    wl = 0;
    @(negedge clk);
    while (cpu_wait) begin
      wl++;
      if (wl > 200) begin
        check_val("wait_bound", 32'(wl), 32'(exp_wait));
        break;
      end
      @(posedge clk); #1;
      scramble_inputs();
      @(negedge clk);
    end
    check_val("wait_len", 32'(wl), 32'(exp_wait));
    check_val("rdata", {24'd0, cpu_rdata}, {24'd0, exp_rdata});
    check_val("err", {31'd0, err_sticky}, {31'd0, err_model});
    check_val("n_aw", 32'(n_aw - aw0), 32'(is_axi && !rd));
    check_val("n_w", 32'(n_w - w0), 32'(is_axi && !rd));
    check_val("n_ar", 32'(n_ar - ar0), 32'(is_axi && rd));
    check_val("n_int", 32'(n_int - i0), 32'(is_int));
    check_val("valid_after_hs", 32'(n_extra - x0), 32'd0);
    if (is_axi && !rd) begin
      check_val("awaddr", seen_awaddr, a);
      check_val("wdata", seen_wdata, d);
      check_val("wstrb", {28'd0, seen_wstrb}, {28'd0, ws});
    end
    if (is_axi && rd) check_val("araddr", seen_araddr, a);
    if (is_int) begin
      check_val("int_addr", {20'd0, seen_int_addr}, {20'd0, a[11:0]});
      check_val("int_type", {29'd0, seen_int_type}, {29'd0, typ});
      check_val("int_we", {31'd0, seen_int_we}, {31'd0, ~rd});
      if (!rd) check_val("int_wdata", {24'd0, seen_int_wdata}, {24'd0, lane});
    end
    @(posedge clk); #1;
    cyc_valid = 1'b0;
    scramble_inputs();
    @(negedge clk);
    check_val("wait_after_drop", {31'd0, cpu_wait}, 32'd0);
    check_val("rdata_hold", {24'd0, cpu_rdata}, {24'd0, exp_rdata});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0] typ;
    rst = 1'b1; cyc_valid = 1'b0;
    scramble_inputs();
    set_dly(0, 0, 0, 0, 0);
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; r_data_cfg = 32'h0; int_val = 8'h00;
    exp_rdata = 8'hFF; err_model = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_wait", {31'd0, cpu_wait}, 32'd0);
    check_val("rst_rdata", {24'd0, cpu_rdata}, 32'hFF);
    check_val("rst_err", {31'd0, err_sticky}, 32'd0);
    check_val("rst_valids", {29'd0, bus.awvalid, bus.wvalid, bus.arvalid}, 32'd0);
    check_val("rst_readys", {30'd0, bus.bready, bus.rready}, 32'd0);
    check_val("rst_int_en", {31'd0, int_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Delayed AXI read of byte lane 2.
    set_dly(0, 0, 0, 3, 3); r_data_cfg = 32'hAABBCCDD;
    run_cycle(1'b1, ADDR_TYPE_AXI, 32'h4000_0002, $urandom, 4'hF);
    check_val("axi_rd_byte", {24'd0, cpu_rdata}, 32'hBB);
    // AXI write with W accepted two cycles before AW and a late B.
    set_dly(2, 0, 1, 0, 0);
    run_cycle(1'b0, ADDR_TYPE_AXI, 32'h2000_0102, 32'h5A5A5A5A, 4'b0100);
    // Error response, then an OKAY read: error stays set.
    set_dly(0, 0, 0, 0, 0); r_resp_cfg = 2'b10; r_data_cfg = 32'h1122_3344;
    run_cycle(1'b1, ADDR_TYPE_AXI, 32'h4000_0000, 32'h0, 4'hF);
    r_resp_cfg = 2'b00;
    run_cycle(1'b1, ADDR_TYPE_AXI, 32'h4000_0001, 32'h0, 4'hF);
    check_val("err_stays", {31'd0, err_sticky}, 32'd1);
    // Internal read and write.
    int_val = 8'h3C;
    run_cycle(1'b1, ADDR_TYPE_RAM, 32'h0000_0ABC, 32'h0, 4'h1);
    run_cycle(1'b0, ADDR_TYPE_LED, 32'h0000_0123, 32'h9696_9696, 4'h8);
    // Unknown write and no-op.
    run_cycle(1'b0, ADDR_TYPE_UNKNOWN, 32'hDEAD_BEEF, 32'h1234_5678, 4'h2);
    run_cycle(1'b1, ADDR_TYPE_NOT_OP, 32'h0, 32'h0, 4'h0);

    // Reset in the middle of an address phase with the CPU cycle still live.
    set_dly(0, 0, 0, 20, 0);
    @(posedge clk); #1;
    cyc_valid = 1'b1; is_read = 1'b1; addr_type = ADDR_TYPE_AXI; a32 = 32'h4000_0010;
    repeat (2) @(negedge clk);
    check_val("ar_pending", {31'd0, bus.arvalid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("ar_abort", {31'd0, bus.arvalid}, 32'd0);
    check_val("wait_abort", {31'd0, cpu_wait}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    err_model = 1'b0; exp_rdata = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("no_restart", {30'd0, cpu_wait, bus.arvalid}, 32'd0);
    end
    check_val("err_cleared", {31'd0, err_sticky}, 32'd0);
    check_val("rdata_reset", {24'd0, cpu_rdata}, 32'hFF);
    @(posedge clk); #1;
    cyc_valid = 1'b0;
    set_dly(0, 0, 0, 1, 0); r_data_cfg = 32'h0F1E_2D3C;
    run_cycle(1'b1, ADDR_TYPE_AXI, 32'h4000_0013, 32'h0, 4'hF);

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      typ = 3'($urandom);
      if ($urandom_range(0, 2) == 0) typ = ADDR_TYPE_AXI;
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      b_resp_cfg = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_resp_cfg = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_data_cfg = $urandom;
      int_val    = 8'($urandom);
      run_cycle(1'($urandom), typ, $urandom, $urandom, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
